// File: rtl/io_dev_ctrl_if.sv
// Processor-side bus for the memory-mapped I/O page: address, write data/strobe,
// page select and combinational read data.
interface io_dev_ctrl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] din;
  logic             we;
  logic             sel;
  logic [DBITS-1:0] dout;

  modport master (output addr, output din, output we, input sel, input dout);
  modport slave  (input addr, input din, input we, output sel, output dout);
endinterface

// File: rtl/io_dev_ctrl.sv
// Memory-mapped KEY/SW/LED/HEX controller: synchronised + debounced inputs, sticky key events.
// Optional 16-bit millisecond timer at offset 0x30 when IO_TIMER_EN is defined.
module io_dev_ctrl #(
  parameter int         DBITS        = 16,
  parameter logic [7:0] IO_PAGE      = 8'hF0,
  parameter int         DEB_CYCLES   = 500000,
  parameter int         TICKS_PER_MS = 50000
) (
  input  logic         clk,
  input  logic         rst,
  io_dev_ctrl_if.slave bus,
  input  logic [3:0]   key,
  input  logic [9:0]   sw,
  output logic [9:0]   ledr,
  output logic [7:0]   ledg,
  output logic [6:0]   hex0,
  output logic [6:0]   hex1,
  output logic [6:0]   hex2,
  output logic [6:0]   hex3
);
  localparam int             NIN      = 14;
  localparam int             CW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [NIN-1:0] IN_RST   = {10'b0, 4'hF};
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [NIN-1:0] raw;
  logic [NIN-1:0] synced;
  logic [NIN-1:0] db;
  logic [NIN-1:0] accept;

  assign raw = {sw, key};

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_in
      logic          s1_reg;
      logic          s2_reg;
      logic          stable_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_reg     <= IN_RST[gi];
          s2_reg     <= IN_RST[gi];
          stable_reg <= IN_RST[gi];
          cnt_reg    <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= s2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign synced[gi] = s2_reg;
      assign db[gi]     = stable_reg;
      assign accept[gi] = (s2_reg != stable_reg) && (cnt_reg == CNT_LAST);
    end
  endgenerate

  // A press is a debounced key about to be accepted at level 0 (keys are active-low).
  logic [3:0] press;
  assign press = accept[3:0] & ~synced[3:0];

  logic [7:0] offset;
  logic       wr;
  assign bus.sel = (bus.addr[15:8] == IO_PAGE);
  assign offset  = bus.addr[7:0] & 8'hFE;
  assign wr      = bus.we && bus.sel;

  logic [9:0]  ledr_reg;
  logic [7:0]  ledg_reg;
  logic [15:0] hexdata_reg;
  logic [3:0]  ev_reg;
  logic [3:0]  ovr_reg;
  logic [3:0]  clr_ev;
  logic [3:0]  clr_ovr;

  assign clr_ev  = (wr && offset == 8'h20) ? bus.din[3:0] : 4'h0;
  assign clr_ovr = (wr && offset == 8'h20) ? bus.din[7:4] : 4'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ledr_reg    <= '0;
      ledg_reg    <= '0;
      hexdata_reg <= '0;
      ev_reg      <= '0;
      ovr_reg     <= '0;
    end else begin
      if (wr && offset == 8'h08) ledr_reg    <= bus.din[9:0];
      if (wr && offset == 8'h0C) ledg_reg    <= bus.din[7:0];
      if (wr && offset == 8'h10) hexdata_reg <= bus.din[15:0];
      // New events override a same-cycle W1C clear.
      ev_reg  <= (ev_reg & ~clr_ev) | press;
      ovr_reg <= (ovr_reg & ~clr_ovr) | (press & ev_reg);
    end
  end

  logic [15:0] timer_rd;
`ifdef IO_TIMER_EN
  localparam int            PW       = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MS - 1);
  logic [PW-1:0] presc_reg;
  logic [15:0]   timer_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      timer_reg <= '0;
    end else if (wr && offset == 8'h30) begin
      presc_reg <= '0;
      timer_reg <= bus.din[15:0];
    end else if (presc_reg == PRE_LAST) begin
      presc_reg <= '0;
      timer_reg <= timer_reg + 16'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end
  assign timer_rd = timer_reg;
`else
  assign timer_rd = 16'hDEAD;
`endif

  logic [DBITS-1:0] rd_next;
  always_comb begin
    rd_next = DBITS'(16'hDEAD);
    case (offset)
      8'h00:   rd_next = DBITS'({12'b0, db[3:0]});
      8'h04:   rd_next = DBITS'({6'b0, db[13:4]});
      8'h08:   rd_next = DBITS'({6'b0, ledr_reg});
      8'h0C:   rd_next = DBITS'({8'b0, ledg_reg});
      8'h10:   rd_next = DBITS'(hexdata_reg);
      8'h20:   rd_next = DBITS'({8'b0, ovr_reg, ev_reg});
      8'h30:   rd_next = DBITS'(timer_rd);
      default: rd_next = DBITS'(16'hDEAD);
    endcase
  end
  assign bus.dout = rd_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [6:0] hex_arr [4];
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hex
      assign hex_arr[gi] = seg7(hexdata_reg[4*gi +: 4]);
    end
  endgenerate

  assign hex0 = hex_arr[0];
  assign hex1 = hex_arr[1];
  assign hex2 = hex_arr[2];
  assign hex3 = hex_arr[3];
  assign ledr = ledr_reg;
  assign ledg = ledg_reg;
endmodule

// File: tb/tb_io_dev_ctrl.sv
// Bench for io_dev_ctrl: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a window-based behavioural model.
module tb_io_dev_ctrl;
  localparam int DEB = 4;
  localparam int TK  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'hF;
  logic [9:0] sw  = '0;
  logic [9:0] ledr;
  logic [7:0] ledg;
  logic [6:0] hex0, hex1, hex2, hex3;

  io_dev_ctrl_if #(.DBITS(16)) bus ();

  io_dev_ctrl #(
    .DBITS(16), .IO_PAGE(8'hF0), .DEB_CYCLES(DEB), .TICKS_PER_MS(TK)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .key(key), .sw(sw),
    .ledr(ledr), .ledg(ledg), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: a debounced bit flips once the last DEB synchronised samples
  // (raw samples delayed two clocks) all disagree with it.
  logic [13:0] samp [DEB+1];
  logic [3:0]  m_key;
  logic [9:0]  m_sw;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic [15:0] m_hex;
  logic [3:0]  m_ev, m_ovr;
  int          m_load, m_cyc;

  always @(posedge clk or posedge rst) begin : model
    logic [13:0] cur, nst;
    logic [3:0]  prs, cev, covr;
    logic        wsel;
    logic [7:0]  off;
    bit          opp;
    if (rst) begin
      for (int j = 0; j <= DEB; j++) samp[j] = 14'h000F;
      m_key = 4'hF; m_sw = '0; m_ledr = '0; m_ledg = '0; m_hex = '0;
      m_ev = '0; m_ovr = '0; m_load = 0; m_cyc = 0;
    end else begin
      cur = {m_sw, m_key};
      for (int b = 0; b < 14; b++) begin
        opp = 1'b1;
        for (int j = 1; j <= DEB; j++) if (samp[j][b] == cur[b]) opp = 1'b0;
        nst[b] = opp ? ~cur[b] : cur[b];
      end
      prs  = m_key & ~nst[3:0];
      wsel = bus.we && (bus.addr[15:8] == 8'hF0);
      off  = bus.addr[7:0] & 8'hFE;
      cev  = '0;
      covr = '0;
      if (wsel) begin
        case (off)
          8'h08: m_ledr = bus.din[9:0];
          8'h0C: m_ledg = bus.din[7:0];
          8'h10: m_hex  = bus.din;
          8'h20: begin cev = bus.din[3:0]; covr = bus.din[7:4]; end
          default: ;
        endcase
      end
      m_ovr = (m_ovr & ~covr) | (prs & m_ev);
      m_ev  = (m_ev & ~cev) | prs;
      if (wsel && off == 8'h30) begin
        m_load = int'(bus.din);
        m_cyc  = 0;
      end else begin
        m_cyc++;
      end
      m_key = nst[3:0];
      m_sw  = nst[13:4];
      for (int j = DEB; j > 0; j--) samp[j] = samp[j-1];
      samp[0] = {sw, key};
    end
  end

  function automatic logic [15:0] exp_dout(input logic [15:0] a);
    logic [7:0] o;
    o = a[7:0] & 8'hFE;
    case (o)
      8'h00: return {12'b0, m_key};
      8'h04: return {6'b0, m_sw};
      8'h08: return {6'b0, m_ledr};
      8'h0C: return {8'b0, m_ledg};
      8'h10: return m_hex;
      8'h20: return {8'b0, m_ovr, m_ev};
`ifdef IO_TIMER_EN
      8'h30: return 16'(m_load + (m_cyc / TK));
`endif
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("m_sel", 32'(bus.sel), 32'(bus.addr[15:8] == 8'hF0));
      if (bus.addr[15:8] == 8'hF0) chk("m_dout", 32'(bus.dout), 32'(exp_dout(bus.addr)));
      chk("m_ledr", 32'(ledr), 32'(m_ledr));
      chk("m_ledg", 32'(ledg), 32'(m_ledg));
      chk("m_hex0", 32'(hex0), 32'(seg_tab[m_hex[3:0]]));
      chk("m_hex1", 32'(hex1), 32'(seg_tab[m_hex[7:4]]));
      chk("m_hex2", 32'(hex2), 32'(seg_tab[m_hex[11:8]]));
      chk("m_hex3", 32'(hex3), 32'(seg_tab[m_hex[15:12]]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr = a; bus.din = d; bus.we = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
    $display("wr   %h <= %h", a, d);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
    bus.addr = a;
    @(negedge clk);
    chk(name, 32'(bus.dout), 32'(exp));
    $display("rd   %h -> %h (want %h)", a, bus.dout, exp);
    @(posedge clk); #1;
  endtask

  task automatic now_chk(input string name, input logic [15:0] exp);
    @(negedge clk);
    chk(name, 32'(bus.dout), 32'(exp));
    $display("rd   %h -> %h (want %h)", bus.addr, bus.dout, exp);
  endtask

  initial begin
    bus.addr = '0; bus.din = '0; bus.we = 1'b0;
    step(3);
    rst = 1'b0;
    chk_on = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_ledg", 32'(ledg), 32'h0);
    chk("rst_hex0", 32'(hex0), 32'h40);
    chk("rst_hex3", 32'(hex3), 32'h40);
    step(1);
    rd_chk("rst_keyctl", 16'hF020, 16'h0000);
    rd_chk("rst_key",    16'hF000, 16'h000F);
    rd_chk("rst_sw",     16'hF004, 16'h0000);

    // LED / HEX writes
    wr(16'hF008, 16'h03FF);
    wr(16'hF00C, 16'h00A5);
    wr(16'hF010, 16'h1A2F);
    @(negedge clk);
    chk("led_ledr", 32'(ledr), 32'h3FF);
    chk("led_ledg", 32'(ledg), 32'hA5);
    chk("hex3_1",   32'(hex3), 32'h79);
    chk("hex2_A",   32'(hex2), 32'h08);
    chk("hex1_2",   32'(hex1), 32'h24);
    chk("hex0_F",   32'(hex0), 32'h0E);
    step(1);
    rd_chk("rb_ledr",  16'hF008, 16'h03FF);
    rd_chk("rb_hex",   16'hF010, 16'h1A2F);
    rd_chk("unmapped", 16'hF040, 16'hDEAD);
    rd_chk("odd_addr", 16'hF009, 16'h03FF);

    // debounce: 3-clock glitch rejected, held press accepted exactly 6 clocks later
    bus.addr = 16'hF000;
    key[1] = 1'b0; step(3);
    key[1] = 1'b1; step(10);
    now_chk("glitch", 16'h000F);
    step(1);
    key[1] = 1'b0;
    repeat (5) @(posedge clk);
    now_chk("deb_early", 16'h000F);
    @(posedge clk);
    now_chk("deb_ontime", 16'h000D);
    step(1);
    rd_chk("ev_set", 16'hF020, 16'h0002);

    // events, overrun, W1C, set-wins-over-clear
    key[1] = 1'b1; step(10);
    key[1] = 1'b0; step(10);
    rd_chk("overrun", 16'hF020, 16'h0022);
    wr(16'hF020, 16'h0002);
    rd_chk("w1c_ev", 16'hF020, 16'h0020);
    key[1] = 1'b1; step(10);
    rd_chk("release", 16'hF020, 16'h0020);
    key[1] = 1'b0; step(10);
    rd_chk("repress", 16'hF020, 16'h0022);
    key[1] = 1'b1; step(10);
    key[1] = 1'b0;
    repeat (5) @(posedge clk); #1;
    wr(16'hF020, 16'h0020);
    rd_chk("set_wins", 16'hF020, 16'h0022);

    // switch path and reset mid-debounce
    bus.addr = 16'hF004;
    sw = 10'h2AA;
    repeat (5) @(posedge clk);
    now_chk("sw_early", 16'h0000);
    @(posedge clk);
    now_chk("sw_ontime", 16'h02AA);
    step(1);
    sw = 10'h155;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    now_chk("sw_rst", 16'h0000);
    chk("rst_ledr2", 32'(ledr), 32'h0);
    step(1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    now_chk("sw_requal_early", 16'h0000);
    @(posedge clk);
    now_chk("sw_requal", 16'h0155);
    step(1);

    // timer
`ifdef IO_TIMER_EN
    wr(16'hF030, 16'hFFFF);
    now_chk("tmr_load", 16'hFFFF);
    repeat (2) @(posedge clk);
    now_chk("tmr_hold", 16'hFFFF);
    @(posedge clk);
    now_chk("tmr_wrap", 16'h0000);
    step(1);
`else
    wr(16'hF030, 16'h1234);
    rd_chk("tmr_absent", 16'hF030, 16'hDEAD);
`endif

    // randomized traffic, checked every cycle by the model compare process
    for (int n = 0; n < 1500; n++) begin
      int kb, sb;
      logic [7:0] off;
      if ($urandom_range(0, 7) == 0) begin
        kb = $urandom_range(0, 3);
        key[kb] = ~key[kb];
      end
      if ($urandom_range(0, 5) == 0) begin
        sb = $urandom_range(0, 9);
        sw[sb] = ~sw[sb];
      end
      case ($urandom_range(0, 7))
        0: off = 8'h00;
        1: off = 8'h04;
        2: off = 8'h08;
        3: off = 8'h0C;
        4: off = 8'h10;
        5: off = 8'h20;
        6: off = 8'h30;
        default: off = 8'($urandom);
      endcase
      off[0] = 1'($urandom_range(0, 1));
      bus.addr = {($urandom_range(0, 9) == 0) ? 8'h3C : 8'hF0, off};
      bus.din  = 16'($urandom);
      bus.we   = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    bus.we = 1'b0;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
